// File: rtl/hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_unit
//  Purpose  : HI/LO register file, multiplier sequencing and stall interlock.
//             Optional done-cycle read forwarding under macro HILO_FWD_EN.
//  Revision : 1.0  initial release
// ============================================================================
module hilo_unit #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    output logic             mult_control,
    input  logic             mult_done,
    input  logic [WIDTH-1:0] mult_hi,
    input  logic [WIDTH-1:0] mult_lo,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_sel,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             stall,
    output logic             timeout_err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_hi, w_hi_nxt;
    logic [WIDTH-1:0] r_lo, w_lo_nxt;
    logic             r_timeout_err, w_timeout_err_nxt;
    logic             w_busy;
    logic             w_rd_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_hi          <= w_hi_nxt;
            r_lo          <= w_lo_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_hi_nxt          = r_hi;
        w_lo_nxt          = r_lo;
        w_timeout_err_nxt = r_timeout_err;
        case (r_state)
            S_IDLE: begin
                if (wr_hi) w_hi_nxt = wdata;
                if (wr_lo) w_lo_nxt = wdata;
                if (mult_start) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = '0;
                end
            end
            S_BUSY: begin
                // A done pulse on the final counted cycle still captures cleanly.
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (mult_done) begin
                    w_hi_nxt    = mult_hi;
                    w_lo_nxt    = mult_lo;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_timeout_err_nxt = 1'b1;
                    w_state_nxt       = S_IDLE;
                    w_cnt_nxt         = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_busy       = (r_state == S_BUSY);
    assign busy         = w_busy;
    assign mult_control = w_busy;
    assign timeout_err  = r_timeout_err;

`ifdef HILO_FWD_EN
    assign w_rd_stall = rd_en & ~mult_done;
    assign rdata      = (w_busy & mult_done) ? (rd_sel ? mult_hi : mult_lo)
                                             : (rd_sel ? r_hi : r_lo);
`else
    assign w_rd_stall = rd_en;
    assign rdata      = rd_sel ? r_hi : r_lo;
`endif

    assign stall = w_busy & (mult_start | wr_hi | wr_lo | w_rd_stall);

endmodule
`default_nettype wire

// File: tb/tb_hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hilo_unit
//  Purpose  : Directed self-checking bench for hilo_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hilo_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             mult_start;
    logic             mult_control;
    logic             mult_done;
    logic [WIDTH-1:0] mult_hi;
    logic [WIDTH-1:0] mult_lo;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             rd_sel;
    logic             rd_en;
    logic [WIDTH-1:0] rdata;
    logic             busy;
    logic             stall;
    logic             timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    int cycles;

    hilo_unit #(.WIDTH(WIDTH), .TIMEOUT(40), .CNT_W(6)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .mult_start   (mult_start),
        .mult_control (mult_control),
        .mult_done    (mult_done),
        .mult_hi      (mult_hi),
        .mult_lo      (mult_lo),
        .wr_hi        (wr_hi),
        .wr_lo        (wr_lo),
        .wdata        (wdata),
        .rd_sel       (rd_sel),
        .rd_en        (rd_en),
        .rdata        (rdata),
        .busy         (busy),
        .stall        (stall),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input string tag, input logic sel, input logic [31:0] exp);
        rd_sel = sel;
        #1;
        check(tag, rdata, exp);
    endtask

    // Start a multiply and run until busy drops. done_at=0 means never pulse done.
    // probe_wr exercises stalled writes/starts mid-operation; probe_rd reads HI in the done cycle.
    task automatic run_mult(input int done_at, input logic [31:0] h, input logic [31:0] l,
                            input bit probe_wr, input bit probe_rd, output int n);
        mult_start = 1'b1;
        #1;
        check("start_idle_nostall", {31'b0, stall}, 32'd0);
        tick;
        mult_start = 1'b0;
        n = 0;
        while (busy && n < 60) begin
            n++;
            if (n == 1) check("mult_control_hi", {31'b0, mult_control}, 32'd1);
            if (probe_wr && n == 5) begin
                wr_lo = 1'b1; wdata = 32'd5;
                #1;
                check("busy_wr_stall", {31'b0, stall}, 32'd1);
            end
            if (probe_wr && n == 6) begin
                read_chk("busy_lo_unchanged", 1'b0, 32'd0);
                mult_start = 1'b1;
                #1;
                check("busy_start_stall", {31'b0, stall}, 32'd1);
            end
            if (n == done_at) begin
                mult_done = 1'b1; mult_hi = h; mult_lo = l;
                if (probe_rd) begin
                    rd_en = 1'b1;
                    rd_sel = 1'b1;
                    #1;
`ifdef HILO_FWD_EN
                    check("done_rd_stall", {31'b0, stall}, 32'd0);
                    check("done_rd_fwd", rdata, h);
`else
                    check("done_rd_stall", {31'b0, stall}, 32'd1);
`endif
                end
            end
            tick;
            wr_lo = 1'b0; mult_start = 1'b0; mult_done = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; mult_start = 1'b0; mult_done = 1'b0;
        mult_hi = '0; mult_lo = '0; wr_hi = 1'b0; wr_lo = 1'b0;
        wdata = '0; rd_sel = 1'b0; rd_en = 1'b0;
        tick; tick;
        reset = 1'b0;

        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_mult_control", {31'b0, mult_control}, 32'd0);
        check("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
        read_chk("rst_lo", 1'b0, 32'd0);
        read_chk("rst_hi", 1'b1, 32'd0);

        // MTHI then MFHI
        wr_hi = 1'b1; wdata = 32'hDEADBEEF;
        tick;
        wr_hi = 1'b0;
        rd_en = 1'b1;
        read_chk("mthi_mfhi", 1'b1, 32'hDEADBEEF);
        check("mfhi_idle_stall", {31'b0, stall}, 32'd0);
        rd_en = 1'b0;

        // 33-cycle multiply with stalled write in the middle
        run_mult(33, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, cycles);
        check("mult_busy_cycles", cycles, 32'd33);
        check("mult_idle_after", {31'b0, busy}, 32'd0);
        rd_en = 1'b1;
        read_chk("mflo_after_mult", 1'b0, 32'h8000_0000);
        read_chk("mfhi_after_mult", 1'b1, 32'h0000_0001);
        check("rd_after_stall", {31'b0, stall}, 32'd0);
        rd_en = 1'b0;
        wr_lo = 1'b1; wdata = 32'd5;
        #1;
        check("retry_wr_stall", {31'b0, stall}, 32'd0);
        tick;
        wr_lo = 1'b0;
        read_chk("retry_wr_lo", 1'b0, 32'd5);

        // Read HI in the done cycle
        run_mult(3, 32'd7, 32'd9, 1'b0, 1'b1, cycles);
        check("short_busy_cycles", cycles, 32'd3);
        check("post_done_stall", {31'b0, stall}, 32'd0);
        read_chk("post_done_hi", 1'b1, 32'd7);
        read_chk("post_done_lo", 1'b0, 32'd9);
        rd_en = 1'b0;

        // Done exactly on the last allowed cycle: capture wins
        run_mult(40, 32'd11, 32'd12, 1'b0, 1'b0, cycles);
        check("edge_busy_cycles", cycles, 32'd40);
        check("edge_no_err", {31'b0, timeout_err}, 32'd0);
        read_chk("edge_hi", 1'b1, 32'd11);
        read_chk("edge_lo", 1'b0, 32'd12);

        // Timeout abort
        run_mult(0, 32'd0, 32'd0, 1'b0, 1'b0, cycles);
        check("to_busy_cycles", cycles, 32'd40);
        check("to_err", {31'b0, timeout_err}, 32'd1);
        check("to_mult_control", {31'b0, mult_control}, 32'd0);
        read_chk("to_hi_kept", 1'b1, 32'd11);
        read_chk("to_lo_kept", 1'b0, 32'd12);
        tick;
        check("to_err_sticky", {31'b0, timeout_err}, 32'd1);

        // Reset in busy cycle 10
        mult_start = 1'b1;
        tick;
        mult_start = 1'b0;
        repeat (9) tick;
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        mult_done = 1'b1; mult_hi = 32'h55; mult_lo = 32'h66;
        tick;
        reset = 1'b0; mult_done = 1'b0;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_mult_control", {31'b0, mult_control}, 32'd0);
        check("midrst_err", {31'b0, timeout_err}, 32'd0);
        read_chk("midrst_hi", 1'b1, 32'd0);
        read_chk("midrst_lo", 1'b0, 32'd0);
        mult_done = 1'b1; mult_hi = 32'hFF; mult_lo = 32'hEE;
        tick;
        mult_done = 1'b0;
        check("stray_done_busy", {31'b0, busy}, 32'd0);
        read_chk("stray_done_hi", 1'b1, 32'd0);
        read_chk("stray_done_lo", 1'b0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
